// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: ALU op classes, funct codes,
// the internal ALU function enum and the multiplier FSM state enum.
package mips_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_MFHI = 6'h10;
    localparam logic [5:0] FUNCT_MFLO = 6'h12;
    localparam logic [5:0] FUNCT_MULT = 6'h18;

    typedef enum logic [3:0] {
        FN_NONE,
        FN_ADD,
        FN_SUB,
        FN_AND,
        FN_OR,
        FN_NOR,
        FN_SLT,
        FN_MFHI,
        FN_MFLO,
        FN_MULT
    } alu_fn_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mult_state_e;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle. The upstream pipeline is the master;
// execute_stage is the slave that consumes operands and drives the EX/MEM side.
interface execute_stage_if #(parameter int W = 32);
    import mips_pkg::*;

    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] pc_plus4;
    logic [W-1:0] imm;
    logic [4:0]   rt;
    logic [4:0]   rd;
    logic         reg_dst;
    logic         branch;
    logic         mem_read;
    logic         mem_to_reg;
    logic         mem_write;
    logic         alu_src;
    logic         reg_write;
    logic [1:0]   alu_op;
    logic         flush;

    logic         stall;
    logic [W-1:0] m_branch_target;
    logic         m_zero;
    logic [W-1:0] m_alu_result;
    logic [W-1:0] m_store_data;
    logic [4:0]   m_dest;
    logic         m_branch;
    logic         m_mem_read;
    logic         m_mem_to_reg;
    logic         m_mem_write;
    logic         m_reg_write;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    mult_state_e  mult_state;

    modport master (
        output a, b, pc_plus4, imm, rt, rd, reg_dst, branch, mem_read,
               mem_to_reg, mem_write, alu_src, reg_write, alu_op, flush,
        input  stall, m_branch_target, m_zero, m_alu_result, m_store_data,
               m_dest, m_branch, m_mem_read, m_mem_to_reg, m_mem_write,
               m_reg_write, hi, lo, mult_state
    );

    modport slave (
        input  a, b, pc_plus4, imm, rt, rd, reg_dst, branch, mem_read,
               mem_to_reg, mem_write, alu_src, reg_write, alu_op, flush,
        output stall, m_branch_target, m_zero, m_alu_result, m_store_data,
               m_dest, m_branch, m_mem_read, m_mem_to_reg, m_mem_write,
               m_reg_write, hi, lo, mult_state
    );

endinterface

// File: rtl/mult_seq.sv
// Signed sequential shift-add multiplier with HI/LO. start is a level request honoured only
// in IDLE and only when abort is low; abort drops BUSY back to IDLE; done is a one-cycle pulse
// whose closing edge writes {hi,lo}. busy is high for exactly MULT_CYCLES cycles per multiply.
module mult_seq
    import mips_pkg::*;
#(
    parameter int W           = 32,
    parameter int MULT_CYCLES = 32   // must equal W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic        busy,
    output logic        done,
    output mult_state_e state,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    localparam int CW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(MULT_CYCLES - 1);

    mult_state_e     state_q, state_d;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  acc;
    logic [2*W-1:0]  mcand;
    logic [W-1:0]    mplier;
    logic            neg;
    logic            accept;

    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        return v[W-1] ? -v : v;
    endfunction

    assign accept = (state_q == ST_IDLE) && start && !abort;
    assign state  = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_BUSY;
            ST_BUSY: begin
                if (abort)            state_d = ST_IDLE;
                else if (cnt == LAST) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_BUSY: busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Magnitudes are multiplied unsigned; the sign is reapplied once at the DONE edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        mcand  <= {{W{1'b0}}, mag(a)};
                        mplier <= mag(b);
                        neg    <= a[W-1] ^ b[W-1];
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                ST_BUSY: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                ST_DONE: {hi, lo} <= neg ? -acc : acc;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/execute_stage.sv
// EX stage: ALU-control decode, ALU, branch-target adder, the sequential multiplier
// and the EX/MEM register. stall freezes IF/ID/ID-EX while a MULT is in flight.
module execute_stage
    import mips_pkg::*;
#(
    parameter int W           = 32,
    parameter int MULT_CYCLES = 32
) (
    input  logic clk,
    input  logic rst_n,
    execute_stage_if.slave ex
);
    logic [W-1:0] opb;
    logic [W-1:0] alu_result;
    logic [W-1:0] hi_w, lo_w;
    logic [5:0]   funct;
    alu_fn_e      fn;
    logic         is_mult;
    logic         stall_w;
    logic         mult_busy, mult_done;
    mult_state_e  mstate;

    assign funct   = ex.imm[5:0];
    assign opb     = ex.alu_src ? ex.imm : ex.b;
    assign is_mult = (fn == FN_MULT);

    always_comb begin
        fn = FN_NONE;
        case (ex.alu_op)
            ALUOP_ADD: fn = FN_ADD;
            ALUOP_SUB: fn = FN_SUB;
            ALUOP_SLT: fn = FN_SLT;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD:  fn = FN_ADD;
                    FUNCT_SUB:  fn = FN_SUB;
                    FUNCT_AND:  fn = FN_AND;
                    FUNCT_OR:   fn = FN_OR;
                    FUNCT_NOR:  fn = FN_NOR;
                    FUNCT_SLT:  fn = FN_SLT;
                    FUNCT_MFHI: fn = FN_MFHI;
                    FUNCT_MFLO: fn = FN_MFLO;
                    FUNCT_MULT: fn = FN_MULT;
                    default:    fn = FN_NONE;
                endcase
            end
            default: fn = FN_NONE;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (fn)
            FN_ADD:  alu_result = ex.a + opb;
            FN_SUB:  alu_result = ex.a - opb;
            FN_AND:  alu_result = ex.a & opb;
            FN_OR:   alu_result = ex.a | opb;
            FN_NOR:  alu_result = ~(ex.a | opb);
            FN_SLT:  alu_result = {{(W-1){1'b0}}, ($signed(ex.a) < $signed(opb))};
            FN_MFHI: alu_result = hi_w;
            FN_MFLO: alu_result = lo_w;
            default: alu_result = '0;
        endcase
    end

    mult_seq #(.W(W), .MULT_CYCLES(MULT_CYCLES)) u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .start (is_mult),
        .abort (ex.flush),
        .a     (ex.a),
        .b     (ex.b),
        .busy  (mult_busy),
        .done  (mult_done),
        .state (mstate),
        .hi    (hi_w),
        .lo    (lo_w)
    );

    // The detect cycle stalls combinationally so the MULT stays parked in ID/EX.
    assign stall_w = mult_busy | (is_mult & ~ex.flush & (mstate == ST_IDLE));

    assign ex.stall      = stall_w;
    assign ex.hi         = hi_w;
    assign ex.lo         = lo_w;
    assign ex.mult_state = mstate;

    always_ff @(posedge clk) begin
        if (!rst_n || ex.flush || stall_w) begin
            ex.m_branch_target <= '0;
            ex.m_zero          <= 1'b0;
            ex.m_alu_result    <= '0;
            ex.m_store_data    <= '0;
            ex.m_dest          <= '0;
            ex.m_branch        <= 1'b0;
            ex.m_mem_read      <= 1'b0;
            ex.m_mem_to_reg    <= 1'b0;
            ex.m_mem_write     <= 1'b0;
            ex.m_reg_write     <= 1'b0;
        end else begin
            ex.m_branch_target <= ex.pc_plus4 + (ex.imm << 2);
            ex.m_zero          <= (alu_result == '0);
            ex.m_alu_result    <= alu_result;
            ex.m_store_data    <= ex.b;
            ex.m_dest          <= ex.reg_dst ? ex.rd : ex.rt;
            ex.m_branch        <= ex.branch;
            ex.m_mem_read      <= ex.mem_read;
            ex.m_mem_to_reg    <= ex.mem_to_reg;
            ex.m_mem_write     <= ex.mem_write;
            ex.m_reg_write     <= ex.reg_write & ~is_mult & ~mult_done;
        end
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 32-bit MIPS pipeline. It sits directly downstream of the ID/EX buffer and consumes its registered operands and control bits.
- Contains the ALU, the ALU-control decode, the branch-target adder, a signed multi-cycle multiplier with HI/LO registers, and the EX/MEM output register feeding the memory stage.
- Asserts stall to freeze IF, ID and ID/EX while a MULT is in progress.

Parameters:
- W, 32, datapath width
- MULT_CYCLES, 32, iteration cycles of the shift-add multiplier; must equal W

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- a  in  32  rs operand from ID/EX
- b  in  32  rt operand from ID/EX
- pc_plus4  in  32  fetch PC+4 from ID/EX
- imm  in  32  sign-extended immediate; imm[5:0] is funct
- rt, rd  in  5 each  register specifiers
- reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write  in  1 each  control bits
- alu_op  in  2  ALU operation class
- flush  in  1  squash the current EX instruction (taken branch resolved later)
- stall  out  1  freeze upstream stages (combinational)
- m_branch_target  out  32  registered pc_plus4 + (imm<<2)
- m_zero  out  1  registered (alu_result == 0)
- m_alu_result  out  32  registered ALU / MFHI / MFLO result
- m_store_data  out  32  registered b
- m_dest  out  5  registered rd if reg_dst else rt
- m_branch, m_mem_read, m_mem_to_reg, m_mem_write, m_reg_write  out  1 each  registered control bits
- hi, lo  out  32 each  multiply result registers

Behaviour:
- Reset (rst_n=0 at a rising edge): all m_* outputs, hi and lo go to 0; FSM goes to IDLE; counter goes to 0. A reset during BUSY aborts the multiply; HI/LO are not updated.
- Operand B is imm if alu_src=1, else b.
- ALU control decode:
  - alu_op 00: ADD.
  - alu_op 01: SUB.
  - alu_op 11: SLT.
  - alu_op 10: decode by funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT, 0x10 MFHI, 0x12 MFLO, 0x18 MULT.
  - Unknown funct: result 0.
- Arithmetic wraps mod 2^32; no overflow trap. SLT is a signed compare producing 32'h1 or 0.
- The EX/MEM register loads every cycle, with no latency beyond one register.
  - If flush=1 or stall=1: it loads a bubble. All m_* control bits are 0; data fields are don't-care but are driven 0.
  - MULT instructions load with m_reg_write forced to 0.
- Multiplier FSM:
  - IDLE: if the decoded op is MULT and flush=0, then stall=1. Latch |a| and |b|, latch the sign as a[31]^b[31], clear the accumulator, set counter=0, and go to BUSY.
  - BUSY: stall=1. Perform one shift-add step per cycle and increment the counter. When counter=MULT_CYCLES-1, go to DONE. If flush=1, go to IDLE and discard the result.
  - DONE: stall=0. At the clock edge, {hi,lo} is written with the 64-bit product, negated if the sign is set. The EX/MEM register captures the MULT bubble-equivalent. Go to IDLE. MULT decode is ignored in DONE, so there is no re-trigger.
- Timing: stall is high for exactly 33 consecutive cycles per MULT (1 IDLE-detect cycle plus 32 BUSY cycles).
- Inputs are held stable by the upstream stages while stall=1.
- Back-to-back MULTs: the second MULT is detected in the cycle after DONE.
- MFHI/MFLO immediately after MULT returns the new value, because HI/LO are written at the DONE edge.
- flush in the IDLE-detect cycle: no multiply starts and stall=0 that cycle.

Decomposition:
- Shared package mips_pkg contains:
  - alu_op encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_RTYPE=10, ALUOP_SLT=11)
  - funct constants
  - internal ALU op enum
  - multiplier FSM state enum (IDLE, BUSY, DONE)
- Sub-module mult_seq holds the FSM, counter, accumulator, sign handling and HI/LO, with start/abort/busy/done signals.
- ALU, decode and the EX/MEM register stay in execute_stage.

Test Plan:
- ADD: alu_op=10, funct 0x20, a=5, b=7, rd=3, reg_dst=1, reg_write=1 -> next cycle m_alu_result=12, m_dest=3, m_reg_write=1, m_zero=0.
- BEQ-style: alu_op=01, a=b=0x1234, branch=1, pc_plus4=0x100, imm=4 -> m_zero=1, m_branch_target=0x110, m_branch=1.
- SLT signed: funct 0x2A, a=0xFFFFFFFF, b=1 -> m_alu_result=1. Repeat with a=1, b=0xFFFFFFFF -> 0.
- MULT: a=-5, b=7 -> stall high for 33 cycles, EX/MEM holds bubbles, then hi=0xFFFFFFFF, lo=0xFFFFFFDD. A following MFLO gives m_alu_result=0xFFFFFFDD on its first cycle.
- Flush mid-MULT: assert flush in the 10th BUSY cycle -> stall drops the next cycle, hi/lo unchanged, m_reg_write=0.
- Reset mid-MULT: rst_n=0 for one edge during BUSY -> all outputs 0, hi=lo=0, stall=0 after reset; a subsequent MULT 3*4 gives lo=12, hi=0.
